// File: rtl/fft_radix2_seq.sv
// -----------------------------------------------------------------------------
// fft_radix2_seq
//
// Iterative, in-place radix-2 decimation-in-time FFT of N = 2**LOG2N complex
// points. A frame is streamed in, transformed one butterfly per clock and then
// streamed out in natural bin order. Frames do not overlap.
//
//   LOAD    : accept N samples. Sample k goes to buffer address bitrev(k).
//   COMPUTE : LOG2N stages of N/2 butterflies, one butterfly per clock.
//   UNLOAD  : present bins 0..N-1 in order, with out_last on bin N-1.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid and ready are both high. The producer keeps its payload stable
// while valid is high and ready is low. Neither valid depends combinationally
// on the other side's ready.
//
// Parameters
//   DW    : signed width of each real/imag component (input and output)
//   LOG2N : log2 of the transform size, 1..3
//   SCALE : 1 -> each butterfly output is shifted right by 1 (1/N overall)
//   TW_W  : twiddle width, twiddles are Q1.(TW_W-2)
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : input sample handshake
//   in_re/in_im         : input sample, signed
//   out_valid/out_ready : output bin handshake
//   out_re/out_im       : output bin, signed; zero whenever out_valid is low
//   out_last            : marks bin N-1; zero whenever out_valid is low
//   done                : one-cycle pulse when the last butterfly is written
// -----------------------------------------------------------------------------
module fft_radix2_seq #(
  parameter int DW    = 16,
  parameter int LOG2N = 3,
  parameter int SCALE = 0,
  parameter int TW_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_re,
  output logic signed [DW-1:0] out_im,
  output logic                 out_last,
  output logic                 done
);

  localparam int N  = 1 << LOG2N;
  localparam int AW = LOG2N;                         // buffer address width
  localparam int BW = (LOG2N > 1) ? (LOG2N - 1) : 1; // butterfly counter width
  localparam int EW = DW + 1;                        // butterfly working width
  localparam int PW = DW + TW_W + 1;                 // full complex product width

  localparam logic [AW-1:0] ADDR_LAST  = AW'(N - 1);
  localparam logic [BW-1:0] BFLY_LAST  = BW'(N / 2 - 1);
  localparam logic [1:0]    STAGE_LAST = 2'(LOG2N - 1);

  // Twiddle constants. 1.0 is 2**(TW_W-2); cos(pi/4) is derived from the
  // 16-bit value 11585 and rounded to the configured width.
  localparam longint TW_C_RAW = ((64'sd11585 <<< (TW_W - 2)) + 64'sd8192) >>> 14;
  localparam logic signed [TW_W-1:0] TW_ONE = TW_W'(64'sd1 <<< (TW_W - 2));
  localparam logic signed [TW_W-1:0] TW_C   = TW_W'(TW_C_RAW);

  // Round-half-up constant added before dropping the TW_W-2 fraction bits.
  localparam logic signed [PW-1:0] RND = PW'(64'sd1 <<< (TW_W - 3));

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_COMPUTE = 2'd1,
    S_UNLOAD  = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  // Sample buffer. Contents are don't-care after reset, so no reset here.
  logic signed [DW-1:0] mem_re [N];
  logic signed [DW-1:0] mem_im [N];

  // Counters
  logic [AW-1:0] load_cnt;   // next input sample index k
  logic [AW-1:0] unload_cnt; // next output bin index m
  logic [1:0]    stage;      // butterfly stage s
  logic [BW-1:0] bfly;       // butterfly index b within the stage

  // Handshake / control
  logic load_fire;
  logic unload_fire;
  logic compute_en;
  logic last_bfly;

  // Butterfly addressing
  logic [AW-1:0] bfly_ext;
  logic [AW-1:0] span;       // h = 2**s
  logic [AW-1:0] pair_j;     // j = b mod h
  logic [AW-1:0] idx_p;      // top index
  logic [AW-1:0] idx_q;      // bottom index
  logic [1:0]    tw_idx;     // twiddle exponent of W8

  // Butterfly datapath
  logic signed [TW_W-1:0] w_re, w_im;
  logic signed [DW-1:0]   xp_re, xp_im, xq_re, xq_im;
  logic signed [PW-1:0]   prod_re, prod_im;
  logic signed [PW-1:0]   rnd_re, rnd_im;
  logic signed [EW-1:0]   t_re, t_im;
  logic signed [EW-1:0]   xp_ext_re, xp_ext_im;
  logic signed [EW-1:0]   sum_re, sum_im, dif_re, dif_im;
  logic signed [DW-1:0]   new_p_re, new_p_im, new_q_re, new_q_im;

  // Product bits that fall outside the DW+1 result window.
  logic unused_prod_bits;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) begin
      r[i] = a[AW-1-i];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_LOAD;
    end else begin
      state <= state_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    case (state)
      S_LOAD: begin
        if (load_fire && (load_cnt == ADDR_LAST)) begin
          state_nx = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (last_bfly) begin
          state_nx = S_UNLOAD;
        end
      end
      S_UNLOAD: begin
        if (unload_fire && (unload_cnt == ADDR_LAST)) begin
          state_nx = S_LOAD;
        end
      end
      default: state_nx = S_LOAD;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Output data is forced to zero outside UNLOAD.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_re     = '0;
    out_im     = '0;
    out_last   = 1'b0;
    compute_en = 1'b0;
    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
      end
      S_COMPUTE: begin
        compute_en = 1'b1;
      end
      S_UNLOAD: begin
        out_valid = 1'b1;
        out_re    = mem_re[unload_cnt];
        out_im    = mem_im[unload_cnt];
        out_last  = (unload_cnt == ADDR_LAST);
      end
      default: ;
    endcase
  end

  assign load_fire   = in_valid & in_ready;
  assign unload_fire = out_valid & out_ready;
  assign last_bfly   = compute_en && (stage == STAGE_LAST) && (bfly == BFLY_LAST);

  // ---------------------------------------------------------------------------
  // Counters. load_cnt and unload_cnt wrap to 0 on their N-th handshake, so
  // they are already cleared for the next frame.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_cnt   <= '0;
      unload_cnt <= '0;
      stage      <= '0;
      bfly       <= '0;
    end else begin
      if (load_fire) begin
        load_cnt <= load_cnt + AW'(1);
      end
      if (compute_en) begin
        if (bfly == BFLY_LAST) begin
          bfly  <= '0;
          stage <= (stage == STAGE_LAST) ? 2'd0 : stage + 2'd1;
        end else begin
          bfly <= bfly + BW'(1);
        end
      end
      if (unload_fire) begin
        unload_cnt <= unload_cnt + AW'(1);
      end
    end
  end

  // Registered so the pulse lines up with the first cycle of UNLOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= last_bfly;
    end
  end

  // ---------------------------------------------------------------------------
  // Butterfly addressing:
  //   j = b mod h, p = (b / h) * 2h + j, q = p + h
  //   twiddle exponent = j * 8 / (2h) = j << (2 - s)
  // ---------------------------------------------------------------------------
  always_comb begin
    bfly_ext = AW'(bfly);
    span     = AW'(1) << stage;
    pair_j   = bfly_ext & (span - AW'(1));
    idx_p    = ((bfly_ext >> stage) << (stage + 2'd1)) | pair_j;
    idx_q    = idx_p | span;
    tw_idx   = 2'(pair_j << (2'd2 - stage));
  end

  always_comb begin
    w_re = TW_ONE;
    w_im = '0;
    case (tw_idx)
      2'd0: begin w_re = TW_ONE; w_im = '0;      end
      2'd1: begin w_re = TW_C;   w_im = -TW_C;   end
      2'd2: begin w_re = '0;     w_im = -TW_ONE; end
      default: begin w_re = -TW_C; w_im = -TW_C; end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Butterfly datapath: t = W * x[q] rounded to DW+1 bits, then
  // x[p] + t and x[p] - t in DW+1 bits, then scale or wrap to DW bits.
  // ---------------------------------------------------------------------------
  always_comb begin
    xp_re = mem_re[idx_p];
    xp_im = mem_im[idx_p];
    xq_re = mem_re[idx_q];
    xq_im = mem_im[idx_q];

    prod_re = PW'(w_re) * PW'(xq_re) - PW'(w_im) * PW'(xq_im);
    prod_im = PW'(w_re) * PW'(xq_im) + PW'(w_im) * PW'(xq_re);
    rnd_re  = prod_re + RND;
    rnd_im  = prod_im + RND;

    // Dropping TW_W-2 fraction bits and keeping DW+1 bits is a slice.
    t_re = rnd_re[DW+TW_W-2:TW_W-2];
    t_im = rnd_im[DW+TW_W-2:TW_W-2];

    xp_ext_re = EW'(xp_re);
    xp_ext_im = EW'(xp_im);
    sum_re    = xp_ext_re + t_re;
    sum_im    = xp_ext_im + t_im;
    dif_re    = xp_ext_re - t_re;
    dif_im    = xp_ext_im - t_im;

    new_p_re = (SCALE != 0) ? sum_re[DW:1] : sum_re[DW-1:0];
    new_p_im = (SCALE != 0) ? sum_im[DW:1] : sum_im[DW-1:0];
    new_q_re = (SCALE != 0) ? dif_re[DW:1] : dif_re[DW-1:0];
    new_q_im = (SCALE != 0) ? dif_im[DW:1] : dif_im[DW-1:0];
  end

  assign unused_prod_bits = ^{rnd_re[PW-1:DW+TW_W-1], rnd_re[TW_W-3:0],
                              rnd_im[PW-1:DW+TW_W-1], rnd_im[TW_W-3:0]};

  // ---------------------------------------------------------------------------
  // Buffer writes: bit-reversed load, or an in-place butterfly update. A
  // butterfly reads p and q combinationally and writes both on the same edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem_re[bitrev(load_cnt)] <= in_re;
      mem_im[bitrev(load_cnt)] <= in_im;
    end else if (compute_en) begin
      mem_re[idx_p] <= new_p_re;
      mem_im[idx_p] <= new_p_im;
      mem_re[idx_q] <= new_q_re;
      mem_im[idx_q] <= new_q_im;
    end
  end

endmodule

// File: tb/tb_fft_radix2_seq.sv
// -----------------------------------------------------------------------------
// tb_fft_radix2_seq
//
// Two instances: dut0 with SCALE=0 and dut1 with SCALE=1, both N=8, DW=16,
// TW_W=16. A behavioural fixed-point FFT model fills one expected queue per
// instance; a single falling-edge process checks every output handshake,
// output hold under backpressure, zeroed outputs when idle, in_ready during
// unload, done timing, and reset behaviour.
// -----------------------------------------------------------------------------
module tb_fft_radix2_seq;

  localparam int DW    = 16;
  localparam int LOG2N = 3;
  localparam int N     = 8;
  localparam int TW_W  = 16;
  localparam int W     = 2 * DW + 1;   // {last, re, im}

  localparam int TWR [4] = '{16384, 11585, 0, -11585};
  localparam int TWI [4] = '{0, -11585, -16384, -11585};

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                 in_valid  [2];
  logic                 in_ready  [2];
  logic signed [DW-1:0] in_re     [2];
  logic signed [DW-1:0] in_im     [2];
  logic                 out_valid [2];
  logic                 out_ready [2];
  logic signed [DW-1:0] out_re    [2];
  logic signed [DW-1:0] out_im    [2];
  logic                 out_last  [2];
  logic                 done      [2];

  fft_radix2_seq #(.DW(DW), .LOG2N(LOG2N), .SCALE(0), .TW_W(TW_W)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_re(in_re[0]), .in_im(in_im[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_re(out_re[0]), .out_im(out_im[0]),
    .out_last(out_last[0]), .done(done[0])
  );

  fft_radix2_seq #(.DW(DW), .LOG2N(LOG2N), .SCALE(1), .TW_W(TW_W)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_re(in_re[1]), .in_im(in_im[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_re(out_re[1]), .out_im(out_im[1]),
    .out_last(out_last[1]), .done(done[1])
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  int n_checks = 0;
  int n_errors = 0;
  int ncyc = 0;
  int acc_cnt      [2] = '{0, 0};
  int last_acc_cyc [2] = '{0, 0};
  bit done_pending [2] = '{0, 0};
  int done_cnt     [2] = '{0, 0};
  int frames_sent  [2] = '{0, 0};
  bit stall_prev   [2] = '{0, 0};
  logic [W-1:0] stall_val [2];

  int fr [8];
  int fi [8];
  int yr [8];
  int yi [8];

  // ---------------------------------------------------------------------------
  // Behavioural model: bit-reverse the frame, then run the textbook DIT
  // stages with the fixed-point rounding and wrap rules.
  // ---------------------------------------------------------------------------
  function automatic int sx(input longint v, input int bits);
    longint s;
    s = v <<< (64 - bits);
    return int'(s >>> (64 - bits));
  endfunction

  function automatic void fft_model(input int xr[8], input int xi[8], input bit scale,
                                    output int or_[8], output int oi[8]);
    int ar [8];
    int ai [8];
    for (int k = 0; k < 8; k++) begin
      int rk;
      rk = ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
      ar[rk] = xr[k];
      ai[rk] = xi[k];
    end
    for (int s = 0; s < LOG2N; s++) begin
      int h;
      h = 1 << s;
      for (int base = 0; base < N; base += 2 * h) begin
        for (int j = 0; j < h; j++) begin
          int p, q, w, tr, ti, sr, si, dr, di;
          longint pr, pi;
          p  = base + j;
          q  = p + h;
          w  = j * (8 / (2 * h));
          pr = longint'(TWR[w]) * ar[q] - longint'(TWI[w]) * ai[q];
          pi = longint'(TWR[w]) * ai[q] + longint'(TWI[w]) * ar[q];
          tr = sx((pr + 8192) >>> 14, 17);
          ti = sx((pi + 8192) >>> 14, 17);
          sr = sx(longint'(ar[p] + tr), 17);
          si = sx(longint'(ai[p] + ti), 17);
          dr = sx(longint'(ar[p] - tr), 17);
          di = sx(longint'(ai[p] - ti), 17);
          ar[p] = scale ? (sr >>> 1) : sx(longint'(sr), 16);
          ai[p] = scale ? (si >>> 1) : sx(longint'(si), 16);
          ar[q] = scale ? (dr >>> 1) : sx(longint'(dr), 16);
          ai[q] = scale ? (di >>> 1) : sx(longint'(di), 16);
        end
      end
    end
    or_ = ar;
    oi  = ai;
  endfunction

  function automatic logic [W-1:0] pack(input logic last, input int re, input int im);
    logic [DW-1:0] r, i;
    r = DW'(re);
    i = DW'(im);
    return {last, r, i};
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Compare process: one instance per call, run on every falling edge.
  // ---------------------------------------------------------------------------
  task automatic check_port(input int d);
    logic [W-1:0] got;
    logic [W-1:0] e;
    got = {out_last[d], out_re[d], out_im[d]};

    if (rst) begin
      n_checks++;
      if (out_valid[d] !== 1'b0 || got !== '0 || done[d] !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_outputs dut%0d got valid=%0b done=%0b data=%h want all 0",
                 d, out_valid[d], done[d], got);
      end
      acc_cnt[d]      = 0;
      done_pending[d] = 0;
      stall_prev[d]   = 0;
      return;
    end

    if (in_valid[d] && in_ready[d]) begin
      acc_cnt[d]++;
      if (acc_cnt[d] == N) begin
        acc_cnt[d]      = 0;
        last_acc_cyc[d] = ncyc;
        done_pending[d] = 1;
      end
    end

    // done rises on the 12th rising edge after the accepting edge, so it is
    // seen 13 falling edges after the one that saw the 8th accept.
    if (done[d]) begin
      done_cnt[d]++;
      n_checks++;
      if (!done_pending[d] || (ncyc - last_acc_cyc[d]) != 13 || !out_valid[d]) begin
        n_errors++;
        $display("FAIL done_timing dut%0d got %0d cycles pending=%0b valid=%0b want 13 1 1",
                 d, ncyc - last_acc_cyc[d], done_pending[d], out_valid[d]);
      end
      done_pending[d] = 0;
    end

    if (stall_prev[d]) begin
      n_checks++;
      if (!out_valid[d] || got !== stall_val[d]) begin
        n_errors++;
        $display("FAIL hold dut%0d got valid=%0b data=%h want valid=1 data=%h",
                 d, out_valid[d], got, stall_val[d]);
      end
      stall_prev[d] = 0;
    end

    if (!out_valid[d]) begin
      n_checks++;
      if (got !== '0) begin
        n_errors++;
        $display("FAIL idle_zero dut%0d got %h want 0", d, got);
      end
    end else begin
      n_checks++;
      if (in_ready[d] !== 1'b0) begin
        n_errors++;
        $display("FAIL in_ready_unload dut%0d got %0b want 0", d, in_ready[d]);
      end
      if (out_ready[d]) begin
        n_checks++;
        if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
          n_errors++;
          $display("FAIL bin dut%0d got %h want nothing (queue empty)", d, got);
        end else begin
          e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          if (got !== e) begin
            n_errors++;
            $display("FAIL bin dut%0d got last=%0b re=%0d im=%0d want last=%0b re=%0d im=%0d",
                     d, got[W-1], $signed(got[2*DW-1:DW]), $signed(got[DW-1:0]),
                     e[W-1], $signed(e[2*DW-1:DW]), $signed(e[DW-1:0]));
          end
        end
      end else begin
        stall_prev[d] = 1;
        stall_val[d]  = got;
      end
    end
  endtask

  always @(negedge clk) begin
    ncyc++;
    for (int d = 0; d < 2; d++) begin
      check_port(d);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic send_frame(input int d, input int xr[8], input int xi[8], input bit rnd_gap);
    int er [8];
    int ei [8];
    bit acc;
    int budget;
    fft_model(xr, xi, (d == 1), er, ei);
    for (int k = 0; k < N; k++) begin
      if (d == 0) exp_q0.push_back(pack(k == N - 1, er[k], ei[k]));
      else        exp_q1.push_back(pack(k == N - 1, er[k], ei[k]));
    end
    frames_sent[d]++;
    for (int k = 0; k < N; k++) begin
      if (rnd_gap) begin
        in_valid[d] = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
      in_valid[d] = 1'b1;
      in_re[d]    = DW'(xr[k]);
      in_im[d]    = DW'(xi[k]);
      budget      = 0;
      do begin
        @(negedge clk);
        acc = in_ready[d];
        @(posedge clk);
        #1;
        budget++;
      end while (!acc && budget < 100);
      if (!acc) begin
        n_checks++;
        n_errors++;
        $display("FAIL load_timeout dut%0d got no accept for sample %0d want accept", d, k);
      end
    end
    in_valid[d] = 1'b0;
  endtask

  // mode 0: always ready; mode 1: random ready; mode 2: 3-cycle stall at bin 3.
  // in_valid is driven with junk while the frame is busy; it must be ignored.
  task automatic wait_drain(input int d, input int mode);
    int got_bins;
    int budget;
    int stall_left;
    got_bins   = 0;
    budget     = 0;
    stall_left = 3;
    out_ready[d] = (mode == 1) ? ($urandom_range(0, 9) < 7) : 1'b1;
    while (got_bins < N) begin
      @(negedge clk);
      if (out_valid[d] && out_ready[d]) got_bins++;
      @(posedge clk);
      #1;
      budget++;
      if (budget > 300) begin
        n_checks++;
        n_errors++;
        $display("FAIL drain_timeout dut%0d got %0d bins want %0d", d, got_bins, N);
        break;
      end
      if (got_bins < N) begin
        in_valid[d] = 1'($urandom_range(0, 1));
        in_re[d]    = DW'($urandom);
        in_im[d]    = DW'($urandom);
      end else begin
        in_valid[d] = 1'b0;
      end
      case (mode)
        1: out_ready[d] = ($urandom_range(0, 9) < 7);
        2: begin
          if (got_bins == 3 && stall_left > 0) begin
            out_ready[d] = 1'b0;
            stall_left--;
          end else begin
            out_ready[d] = 1'b1;
          end
        end
        default: out_ready[d] = 1'b1;
      endcase
    end
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
  endtask

  task automatic set_frame(input int r0, input int i0, input int kind);
    // kind 0: impulse at 0, 1: impulse at 1, 2: constant, 3: alternating sign
    for (int k = 0; k < N; k++) begin
      case (kind)
        0: begin fr[k] = (k == 0) ? r0 : 0; fi[k] = (k == 0) ? i0 : 0; end
        1: begin fr[k] = (k == 1) ? r0 : 0; fi[k] = (k == 1) ? i0 : 0; end
        2: begin fr[k] = r0; fi[k] = i0; end
        default: begin fr[k] = (k % 2 == 0) ? r0 : -r0; fi[k] = (k % 2 == 0) ? i0 : -i0; end
      endcase
    end
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  int pin_re [8] = '{100, 71, 0, -71, -100, -71, 0, 71};
  int pin_im [8] = '{0, -71, -100, -71, 0, 71, 100, 71};

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      in_re[d]     = '0;
      in_im[d]     = '0;
      out_ready[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("in_ready_after_reset_dut%0d", d), int'(in_ready[d]), 1);
      chk($sformatf("out_valid_after_reset_dut%0d", d), int'(out_valid[d]), 0);
    end

    // Hand-computed values that pin the model.
    set_frame(100, 0, 1);
    fft_model(fr, fi, 1'b0, yr, yi);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("model_imp1_re%0d", k), yr[k], pin_re[k]);
      chk($sformatf("model_imp1_im%0d", k), yi[k], pin_im[k]);
    end
    set_frame(100, 0, 0);
    fft_model(fr, fi, 1'b0, yr, yi);
    chk("model_imp0_re7", yr[7], 100);
    chk("model_imp0_im3", yi[3], 0);
    set_frame(10, 0, 2);
    fft_model(fr, fi, 1'b0, yr, yi);
    chk("model_const_re0", yr[0], 80);
    chk("model_const_re5", yr[5], 0);
    set_frame(10, 0, 3);
    fft_model(fr, fi, 1'b0, yr, yi);
    chk("model_alt_re4", yr[4], 80);
    chk("model_alt_re0", yr[0], 0);
    set_frame(800, -800, 2);
    fft_model(fr, fi, 1'b1, yr, yi);
    chk("model_scaled_re0", yr[0], 800);
    chk("model_scaled_im0", yi[0], -800);
    chk("model_scaled_re6", yr[6], 0);

    // Directed frames on the unscaled instance.
    set_frame(100, 0, 0);
    send_frame(0, fr, fi, 1'b0);
    wait_drain(0, 0);
    chk("done_once_first_frame", done_cnt[0], 1);
    set_frame(10, 0, 2);
    send_frame(0, fr, fi, 1'b0);
    wait_drain(0, 0);
    set_frame(10, 0, 3);
    send_frame(0, fr, fi, 1'b0);
    wait_drain(0, 0);
    set_frame(100, 0, 1);
    send_frame(0, fr, fi, 1'b0);
    wait_drain(0, 0);

    // Scaled instance, then the same frame with a stall at bin 3.
    set_frame(800, -800, 2);
    send_frame(1, fr, fi, 1'b0);
    wait_drain(1, 0);
    send_frame(1, fr, fi, 1'b0);
    wait_drain(1, 2);

    // Abort a frame mid-compute, then the impulse frame must be exact.
    for (int k = 0; k < N; k++) begin
      fr[k] = int'($urandom_range(0, 65535)) - 32768;
      fi[k] = int'($urandom_range(0, 65535)) - 32768;
    end
    send_frame(0, fr, fi, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q0.delete();
    frames_sent[0]--;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("in_ready_after_abort", int'(in_ready[0]), 1);
    chk("out_valid_after_abort", int'(out_valid[0]), 0);
    set_frame(100, 0, 0);
    send_frame(0, fr, fi, 1'b0);
    wait_drain(0, 0);

    // Random frames with random input gaps and random backpressure.
    for (int r = 0; r < 6; r++) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < N; k++) begin
          if (r % 2 == 0) begin
            fr[k] = int'($urandom_range(0, 65535)) - 32768;
            fi[k] = int'($urandom_range(0, 65535)) - 32768;
          end else begin
            fr[k] = int'($urandom_range(0, 2000)) - 1000;
            fi[k] = int'($urandom_range(0, 2000)) - 1000;
          end
        end
        send_frame(d, fr, fi, 1'b1);
        wait_drain(d, 1);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("leftover_dut0", exp_q0.size(), 0);
    chk("leftover_dut1", exp_q1.size(), 0);
    chk("done_count_dut0", done_cnt[0], frames_sent[0]);
    chk("done_count_dut1", done_cnt[1], frames_sent[1]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    n_checks++;
    n_errors++;
    $display("FAIL watchdog got timeout want completion");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
